// File: rtl/maxpool_window_reader.sv
// ---------------------------------------------------------------------------
// maxpool_window_reader
//
// Sequencer for a 2x2 / stride-2 max-pool compare unit. It walks a signed
// BD-bit feature map held in a dual-read-port synchronous RAM (read latency 1).
// Each cycle it issues one address pair covering one column of a window:
// rd_addr0 points into row r and rd_addr1 points into row r+1. The compare
// unit gets mpen/wincnt aligned with the returned data. After the right-hand
// column of each window, the block captures the finished maximum d and writes
// it to the pooled output memory.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   start     one-cycle pulse; begins a full-map pass when idle
//   busy      high from the cycle after an accepted start until done
//   done      one-cycle pulse after the last output write
//   rd_en     read strobe to the input RAM (both ports)
//   rd_addr0  upper-row address (row r)
//   rd_addr1  lower-row address (row r+1)
//   mpen      compare-unit enable; q0/q1 at its inputs are valid
//   wincnt    compare-unit column select: 0 = left column, 1 = right column
//   d         running window maximum returned by the compare unit
//   wr_en     write strobe to the output RAM
//   wr_addr   pooled output address
//   wr_data   pooled value (unmodified copy of d)
// ---------------------------------------------------------------------------
module maxpool_window_reader #(
    parameter int BD    = 18,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int AW    = 10,
    parameter int OAW   = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           rd_en,
    output logic [AW-1:0]  rd_addr0,
    output logic [AW-1:0]  rd_addr1,
    output logic           mpen,
    output logic           wincnt,
    input  logic [BD-1:0]  d,
    output logic           wr_en,
    output logic [OAW-1:0] wr_addr,
    output logic [BD-1:0]  wr_data
);

    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 2);

    typedef enum logic [1:0] {
        st_idle,
        st_issue,
        st_drain,
        st_done
    } state_t;

    state_t         state_reg;
    logic [CW-1:0]  col_reg;
    logic [RW-1:0]  row_reg;
    logic [OAW-1:0] oaddr_reg;
    logic           drain_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= st_idle;
            col_reg   <= '0;
            row_reg   <= '0;
            oaddr_reg <= '0;
            drain_reg <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr0  <= '0;
            rd_addr1  <= '0;
            mpen      <= 1'b0;
            wincnt    <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            // Stage 1: the RAM returns data the cycle after an issue. The
            // wincnt tag is the column parity of the address that was issued,
            // which is still held in col_reg during that issue cycle.
            mpen   <= rd_en;
            wincnt <= rd_en & col_reg[0];

            // Stage 2: d became final on the falling edge of the right-column
            // cycle. Capture it here, before the next window's left column
            // overwrites it on the following falling edge.
            wr_en <= mpen & wincnt;
            if (mpen && wincnt) begin
                wr_data   <= d;
                wr_addr   <= oaddr_reg;
                oaddr_reg <= oaddr_reg + OAW'(1);
            end

            done <= 1'b0;

            case (state_reg)
                st_idle: begin
                    if (start) begin
                        state_reg <= st_issue;
                        busy      <= 1'b1;
                        rd_en     <= 1'b1;
                        rd_addr0  <= '0;
                        rd_addr1  <= AW'(IMG_W);
                        row_reg   <= '0;
                        col_reg   <= '0;
                        oaddr_reg <= '0;
                    end
                end

                st_issue: begin
                    if (col_reg == COL_LAST) begin
                        if (row_reg == ROW_LAST) begin
                            state_reg <= st_drain;
                            rd_en     <= 1'b0;
                            drain_reg <= 1'b0;
                        end else begin
                            // The lower row was already read with this pair,
                            // so jump forward over it to the next row pair.
                            col_reg  <= '0;
                            row_reg  <= row_reg + RW'(2);
                            rd_addr0 <= rd_addr0 + AW'(IMG_W + 1);
                            rd_addr1 <= rd_addr1 + AW'(IMG_W + 1);
                        end
                    end else begin
                        col_reg  <= col_reg + CW'(1);
                        rd_addr0 <= rd_addr0 + AW'(1);
                        rd_addr1 <= rd_addr1 + AW'(1);
                    end
                end

                st_drain: begin
                    // Two cycles let the last pair pass through stage 1 and
                    // then through stage 2.
                    if (drain_reg) begin
                        state_reg <= st_done;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        drain_reg <= 1'b1;
                    end
                end

                st_done: begin
                    state_reg <= st_idle;
                end

                default: begin
                    state_reg <= st_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_window_reader.sv
// ---------------------------------------------------------------------------
// Testbench for maxpool_window_reader. Three instances (4x4, 2x2 and 28x28
// maps) share the clock and reset. Each instance has its own synchronous
// input-RAM model and compare-unit model.
// ---------------------------------------------------------------------------
module tb_maxpool_window_reader;

    localparam int BD  = 18;
    localparam int AW  = 10;
    localparam int OAW = 8;

    logic clk = 1'b0;
    logic reset;
    logic [2:0] start;
    logic [2:0] busy, done, rd_en, mpen, wincnt, wr_en;
    logic [2:0][AW-1:0]  rd_addr0, rd_addr1;
    logic [2:0][OAW-1:0] wr_addr;
    logic [2:0][BD-1:0]  wr_data;
    logic [2:0][BD-1:0]  d_bus;

    logic signed [BD-1:0] mem [3][1024];

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt      [3] = '{0, 0, 0};
    int done_seen   [3] = '{0, 0, 0};
    int last_writes [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic signed [BD-1:0] smax(input logic signed [BD-1:0] a,
                                                  input logic signed [BD-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // This reference maximum is computed directly from the map contents.
    function automatic logic [BD-1:0] exp_max(input int i, input int o);
        int w, row, col, base;
        logic signed [BD-1:0] m;
        w    = (i == 0) ? 4 : ((i == 1) ? 2 : 28);
        row  = o / (w / 2);
        col  = o % (w / 2);
        base = 2 * row * w + 2 * col;
        m = mem[i][base];
        m = smax(m, mem[i][base + 1]);
        m = smax(m, mem[i][base + w]);
        m = smax(m, mem[i][base + w + 1]);
        return m;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam int W = (gi == 0) ? 4 : ((gi == 1) ? 2 : 28);
            logic signed [BD-1:0] q0, q1, dv;

            maxpool_window_reader #(
                .BD(BD), .IMG_W(W), .IMG_H(W), .AW(AW), .OAW(OAW)
            ) u_dut (
                .clk      (clk),
                .reset    (reset),
                .start    (start[gi]),
                .busy     (busy[gi]),
                .done     (done[gi]),
                .rd_en    (rd_en[gi]),
                .rd_addr0 (rd_addr0[gi]),
                .rd_addr1 (rd_addr1[gi]),
                .mpen     (mpen[gi]),
                .wincnt   (wincnt[gi]),
                .d        (d_bus[gi]),
                .wr_en    (wr_en[gi]),
                .wr_addr  (wr_addr[gi]),
                .wr_data  (wr_data[gi])
            );

            // Input RAM: synchronous read with latency 1.
            always @(posedge clk) begin
                if (rd_en[gi]) begin
                    q0 <= mem[gi][rd_addr0[gi]];
                    q1 <= mem[gi][rd_addr1[gi]];
                end
            end

            // Compare unit: samples on the falling edge and clears when idle.
            always @(negedge clk or negedge reset) begin
                if (!reset)            dv <= '0;
                else if (!mpen[gi])    dv <= '0;
                else if (!wincnt[gi])  dv <= smax(q0, q1);
                else                   dv <= smax(dv, smax(q0, q1));
            end

            assign d_bus[gi] = dv;
        end
    endgenerate

    // Write monitor: checks every output write against the reference model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check("wincnt_without_mpen", 32'(wincnt[i] & ~mpen[i]), 32'd0);
            if (!reset) begin
                wr_cnt[i] = 0;
            end else begin
                if (rd_en[i] && rd_addr0[i] == '0) wr_cnt[i] = 0;
                if (wr_en[i]) begin
                    $display("[%0t] inst%0d write addr=%0d data=%0d", $time, i,
                             wr_addr[i], $signed(wr_data[i]));
                    check("mon_wr_addr", 32'(wr_addr[i]), 32'(wr_cnt[i]));
                    check("mon_wr_data", 32'(wr_data[i]), 32'(exp_max(i, wr_cnt[i])));
                    wr_cnt[i]++;
                end
                if (done[i]) begin
                    done_seen[i]++;
                    last_writes[i] = wr_cnt[i];
                end
            end
        end
    end

    initial begin
        logic [15:0] e_rden, e_mpen, e_win, e_wren, e_busy, e_done;
        int a0_tab [8];
        int wd_tab [4];
        int wk, v;
        logic [BD-1:0] ev;

        for (int k = 0; k < 16; k++) mem[0][k] = BD'(k - 8);
        mem[1][0] = -18'sd1;
        mem[1][1] = -18'sd5;
        mem[1][2] = -18'sd2;
        mem[1][3] = -18'sd3;
        for (int k = 0; k < 784; k++) mem[2][k] = BD'(((k * 37) % 211) - 105);

        // ---- Reset held with start high ----
        reset = 1'b0;
        start = 3'b111;
        repeat (3) @(negedge clk);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_rd_en",  32'(rd_en),  32'd0);
        check("rst_mpen",   32'(mpen),   32'd0);
        check("rst_wincnt", 32'(wincnt), 32'd0);
        check("rst_wr_en",  32'(wr_en),  32'd0);
        check("rst_addr0",  32'(rd_addr0[2]), 32'd0);
        check("rst_wdata",  32'(wr_data[0]), 32'd0);
        start = 3'b000;
        reset = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check("idle_busy",  32'(busy),  32'd0);
            check("idle_rd_en", 32'(rd_en), 32'd0);
        end

        // ---- 4x4 pass, with start re-pulsed mid-pass and in the done cycle ----
        e_rden = 16'h00FF; e_mpen = 16'h01FE; e_win  = 16'h0154;
        e_wren = 16'h02A8; e_busy = 16'h03FF; e_done = 16'h0400;
        a0_tab = '{0, 1, 2, 3, 8, 9, 10, 11};
        wd_tab = '{-3, -1, 5, 7};
        wk = 0;
        start[0] = 1'b1;
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            start[0] = (t == 4 || t == 10);
            check("p4_rd_en",  32'(rd_en[0]),  32'(e_rden[t]));
            check("p4_mpen",   32'(mpen[0]),   32'(e_mpen[t]));
            check("p4_wincnt", 32'(wincnt[0]), 32'(e_win[t]));
            check("p4_wr_en",  32'(wr_en[0]),  32'(e_wren[t]));
            check("p4_busy",   32'(busy[0]),   32'(e_busy[t]));
            check("p4_done",   32'(done[0]),   32'(e_done[t]));
            if (e_rden[t]) begin
                check("p4_addr0", 32'(rd_addr0[0]), 32'(a0_tab[t]));
                check("p4_addr1", 32'(rd_addr1[0]), 32'(a0_tab[t] + 4));
            end
            if (e_wren[t] && wk < 4) begin
                v  = wd_tab[wk];
                ev = v[BD-1:0];
                check("p4_wr_addr", 32'(wr_addr[0]), 32'(wk));
                check("p4_wr_data", 32'(wr_data[0]), 32'(ev));
                wk++;
            end
        end
        start[0] = 1'b0;
        check("p4_done_count",  32'(done_seen[0]),   32'd1);
        check("p4_write_count", 32'(last_writes[0]), 32'd4);

        // ---- 2x2 all-negative map ----
        @(negedge clk);
        start[1] = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            start[1] = 1'b0;
            check("p2_rd_en", 32'(rd_en[1]), 32'(t < 2));
            check("p2_wr_en", 32'(wr_en[1]), 32'(t == 3));
            check("p2_busy",  32'(busy[1]),  32'(t < 4));
            check("p2_done",  32'(done[1]),  32'(t == 4));
            if (t < 2) begin
                check("p2_addr0", 32'(rd_addr0[1]), 32'(t));
                check("p2_addr1", 32'(rd_addr1[1]), 32'(t + 2));
            end
            if (t == 3) begin
                check("p2_wr_data", 32'(wr_data[1]), 32'h3FFFF);
                check("p2_wr_addr", 32'(wr_addr[1]), 32'd0);
            end
        end
        check("p2_write_count", 32'(last_writes[1]), 32'd1);

        // ---- 28x28: asynchronous reset mid-ISSUE, then a full pass ----
        start[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        check("p28_first_rd_en", 32'(rd_en[2]),    32'd1);
        check("p28_first_addr0", 32'(rd_addr0[2]), 32'd0);
        check("p28_first_addr1", 32'(rd_addr1[2]), 32'd28);
        repeat (100) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_busy",    32'(busy[2]),     32'd0);
        check("abort_rd_en",   32'(rd_en[2]),    32'd0);
        check("abort_mpen",    32'(mpen[2]),     32'd0);
        check("abort_wr_en",   32'(wr_en[2]),    32'd0);
        check("abort_addr0",   32'(rd_addr0[2]), 32'd0);
        check("abort_wr_addr", 32'(wr_addr[2]),  32'd0);
        check("abort_wr_data", 32'(wr_data[2]),  32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_done", 32'(done_seen[2]), 32'd0);
        start[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        check("restart_rd_en", 32'(rd_en[2]),    32'd1);
        check("restart_addr0", 32'(rd_addr0[2]), 32'd0);
        for (int k = 0; k < 600 && done_seen[2] == 0; k++) @(negedge clk);
        check("p28_done_count",  32'(done_seen[2]),   32'd1);
        check("p28_write_count", 32'(last_writes[2]), 32'd196);
        repeat (2) @(negedge clk);
        check("p28_busy_after", 32'(busy[2]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/maxpool_window_reader.md
Name: maxpool_window_reader

Overview:
- Sequencer that drives the 2x2/stride-2 max-pool compare unit.
- Scans a signed BD-bit feature map held in a dual-read-port synchronous RAM and issues the two row addresses per window column.
- Drives the compare unit's mpen/wincnt aligned to returned data, captures the finished window maximum d, and writes it to the pooled output memory.
- Sits between conv output buffer and next layer's input buffer.

Parameters:
- BD, 18, data width of feature values and pooled result (two's complement).
- IMG_W, 28, input feature-map width; even, >=2.
- IMG_H, 28, input feature-map height; even, >=2.
- AW, 10, input memory address width; must satisfy IMG_W*IMG_H <= 2^AW.
- OAW, 8, output memory address width; must satisfy (IMG_W/2)*(IMG_H/2) <= 2^OAW.

Ports:
- clk  in  1  clock; all block logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a full-map pool pass when idle.
- busy  out  1  high from the cycle after accepted start until the done pulse.
- done  out  1  one-cycle pulse after the last output write.
- rd_en  out  1  read strobe to input RAM, both ports.
- rd_addr0  out  AW  upper-row address (row r).
- rd_addr1  out  AW  lower-row address (row r+1).
- mpen  out  1  to compare unit; high when q0/q1 at compare inputs are valid.
- wincnt  out  1  to compare unit; 0 = left column of window, 1 = right column.
- d  in  BD  running window maximum from compare unit.
- wr_en  out  1  write strobe to output RAM.
- wr_addr  out  OAW  pooled output address.
- wr_data  out  BD  pooled value (= d sampled).

Behaviour:
- Reset (reset=0, async): all outputs 0; state IDLE; counters r=0, c=0, oaddr=0; pipeline valid bits cleared. Reset mid-pass aborts; no done pulse. After reset release, the block waits for start.
- Input RAM: synchronous read, latency 1. Data for an address issued in cycle t appears on q0/q1 during cycle t+1. The compare unit samples on the falling edge within t+1.
- States:
  - IDLE: start=1 -> ISSUE, r=0, c=0. Other inputs ignored.
  - ISSUE: each cycle, rd_en=1, rd_addr0=r*IMG_W+c, rd_addr1=(r+1)*IMG_W+c.
    - Advance c by 1.
    - When c=IMG_W-1: c=0, r+=2.
    - After issuing r=IMG_H-2, c=IMG_W-1 -> DRAIN.
    - One address pair per cycle, no bubbles.
  - DRAIN: rd_en=0; wait for pipeline empty (2 cycles) -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Pipeline stage 1 is the cycle after issue. mpen = registered rd_en. wincnt = registered (c[0] at issue), i.e. 0 for even columns and 1 for odd columns.
- Stage 2 is the cycle after a stage-1 cycle with wincnt=1. In that cycle: wr_en=1, wr_data=d (d already final from the previous falling edge), wr_addr=oaddr; then oaddr+=1.
  - The capture occurs on the rising edge, before the compare unit overwrites d at the following falling edge with the next window's wincnt=0 data.
- Windows are back-to-back. Throughput is 1 output per 2 cycles. First write occurs 3 cycles after the first issue.
- Total pass length: IMG_W*IMG_H/2 issue cycles + 2 drain + done cycle.
- mpen=0 whenever no valid data is in stage 1. The compare unit then clears d; the block never samples d in those cycles.
- start while busy: ignored. start in the same cycle as done: ignored (block returns to IDLE first).
- Address arithmetic is unsigned modulo 2^AW / 2^OAW. Parameter constraints guarantee no wrap in legal configurations.
- wr_data is an unmodified copy of d; the block has no arithmetic on data.

Test Plan:
- Reset: hold reset=0 with start=1 -> all outputs 0, busy=0; release reset, no activity until a start pulse.
- 4x4 map, values addr k = k-8 (signed), start -> rd_addr pairs (0,4),(1,5),(2,6),(3,7),(8,12),... one per cycle; wr_en at cycles 3,5,7,9 after first issue; wr_data = -3, -1, 5, 7; wr_addr 0..3; done one cycle after the drain completes; busy low after done.
- Timing check: mpen/wincnt sequence across the 4x4 pass = (1,0),(1,1) repeating 8 cycles, then mpen=0; wincnt never 1 without mpen.
- All-negative 2x2 map {-1,-5,-2,-3}, IMG_W=IMG_H=2 -> single write, wr_data=-1 (0x3FFFF for BD=18), wr_addr=0.
- start pulsed again mid-pass and in the done cycle -> ignored; exactly (IMG_W/2)*(IMG_H/2) writes per accepted start.
- Async reset asserted mid-ISSUE on a 28x28 map -> outputs 0 immediately, no done; a new start then restarts from rd_addr0=0, wr_addr=0 and yields all 196 writes.
